bios_boot_loader: RTL

//  Boot-time reader of the BIOS ROM: walks ROM addresses 0..COPY_WORDS-1, absorbs the ROM's
//  1-cycle registered read latency and writes each word into main RAM at RAM_BASE+i.

---
 rtl/bios_pkg.sv | 13 +
 rtl/bios_boot_loader.sv | 136 +++++++++++++
 2 files changed

// File: rtl/bios_pkg.sv
// Shared BIOS geometry and loader FSM encoding, so the ROM and the boot loader agree.
package bios_pkg;

   localparam int BIOS_ADDR_WIDTH = 9;
   localparam int BIOS_WORDS      = 512;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      COPY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bios_boot_loader.sv
// Boot loader: copies BIOS ROM words 0..COPY_WORDS-1 into main RAM at RAM_BASE+i,
// absorbing the ROM's one-cycle registered read latency, and holds the CPU until done.
// Optional feature macro: BIOS_CHECKSUM_EN (wrapping image sum must be zero at DONE).
module bios_boot_loader
   import bios_pkg::*;
#(
   parameter int                        DATA_WIDTH     = 16,
   parameter int                        ROM_ADDR_WIDTH = BIOS_ADDR_WIDTH,
   parameter int                        RAM_ADDR_WIDTH = 16,
   parameter int                        COPY_WORDS     = BIOS_WORDS,
   parameter logic [RAM_ADDR_WIDTH-1:0] RAM_BASE       = '0,
   parameter bit                        AUTO_START     = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0]     rom_q,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0]     ram_data,
   output logic                      ram_we,
   input  logic                      ram_wait,
   output logic                      busy,
   output logic                      done,
   output logic                      cpu_hold,
   output logic                      checksum_ok
);

   localparam int                        LAST_IDX = COPY_WORDS - 1;
   // rd_ptr carries an extra MSB so a full 2**ROM_ADDR_WIDTH copy never aliases word 0
   localparam logic [ROM_ADDR_WIDTH:0]   RD_END   = COPY_WORDS[ROM_ADDR_WIDTH:0];
   localparam logic [ROM_ADDR_WIDTH-1:0] WR_LAST  = LAST_IDX[ROM_ADDR_WIDTH-1:0];

   state_t                    state, state_next;
   logic [ROM_ADDR_WIDTH:0]   rd_ptr;
   logic [ROM_ADDR_WIDTH-1:0] wr_ptr;
   logic                      vld;
   logic                      stall;
   logic                      start_copy;
   logic                      advance;
   logic                      finish;

   assign stall = vld & ram_wait;

   // On a stall the ROM re-reads the pending word so rom_q stays valid for the held write
   assign rom_addr = stall ? wr_ptr : rd_ptr[ROM_ADDR_WIDTH-1:0];
   assign ram_addr = RAM_BASE + RAM_ADDR_WIDTH'(wr_ptr);
   assign ram_data = rom_q;
   assign ram_we   = vld;

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic and per-cycle datapath strobes
   always_comb begin
      state_next = state;
      start_copy = 1'b0;
      advance    = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start || AUTO_START) begin
               state_next = COPY;
               start_copy = 1'b1;
            end
         end
         COPY: begin
            if (!stall) begin
               if (rd_ptr < RD_END) advance = 1'b1;
               if (vld && (wr_ptr == WR_LAST)) begin
                  finish     = 1'b1;
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            if (start) begin
               state_next = COPY;
               start_copy = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Read/write pointers, write-valid pipeline stage and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         vld      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cpu_hold <= 1'b1;
      end else begin
         if (start_copy) begin
            rd_ptr <= '0;
            vld    <= 1'b0;
            busy   <= 1'b1;
            done   <= 1'b0;
         end else if ((state == COPY) && !stall) begin
            if (advance) begin
               wr_ptr <= rd_ptr[ROM_ADDR_WIDTH-1:0];
               rd_ptr <= rd_ptr + 1'b1;
               vld    <= 1'b1;
            end else begin
               vld    <= 1'b0;
            end
         end
         if (finish) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
         end
      end
   end

`ifdef BIOS_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] sum;

   // Wrapping sum of every accepted write; the image's last word makes it zero
   always_ff @(posedge clk) begin
      if (reset)                                     sum <= '0;
      else if (start_copy)                           sum <= '0;
      else if ((state == COPY) && vld && !ram_wait)  sum <= sum + rom_q;
   end

   assign checksum_ok = done & (sum == '0);
`else
   assign checksum_ok = done;
`endif

endmodule
